// File: rtl/instr_mem_arbiter.sv
// ---------------------------------------------------------------------------
// instr_mem_arbiter
//
// Purpose:
//   Shares one single-port instruction memory between NUM_CORES fetch units
//   and a program loader. The loader has fixed priority. The cores are served
//   round-robin. Only one memory transaction is in flight at a time.
//
// Optional feature (macro INSTR_ARB_STATS_EN):
//   When defined, the block adds output stat_conflicts[15:0]. This is a
//   saturating count of grant edges at which two or more requesters were
//   active.
//
// Ports:
//   clock         in   system clock, rising edge
//   clear         in   synchronous active-high reset
//   core_req      in   per-core fetch request, held until its core_valid
//   core_addr     in   packed fetch addresses, core i at [i*ADDR_W +: ADDR_W]
//   core_valid    out  one-cycle pulse marking core_data valid for that core
//   core_data     out  fetched instruction, shared by all cores
//   ld_req        in   loader write request, held until ld_ack
//   ld_addr       in   loader write address
//   ld_data       in   loader write data
//   ld_ack        out  one-cycle pulse, write committed
//   mem_pc        out  memory address
//   mem_hab_escr  out  memory write enable
//   mem_dado      out  memory write data
//   mem_instr     in   memory read data (registered in the memory, 1 edge)
//   busy          out  high whenever the FSM is not in IDLE
//   stat_conflicts out contended-grant counter (INSTR_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module instr_mem_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 10
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    output logic [NUM_CORES-1:0]        core_valid,
    output logic [DATA_W-1:0]           core_data,
    input  logic                        ld_req,
    input  logic [ADDR_W-1:0]           ld_addr,
    input  logic [DATA_W-1:0]           ld_data,
    output logic                        ld_ack,
    output logic [ADDR_W-1:0]           mem_pc,
    output logic                        mem_hab_escr,
    output logic [DATA_W-1:0]           mem_dado,
    input  logic [DATA_W-1:0]           mem_instr,
    output logic                        busy
`ifdef INSTR_ARB_STATS_EN
    ,
    output logic [15:0]                 stat_conflicts
`endif
);

    localparam int IDX_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [IDX_W-1:0]     r_last_grant;
    logic [IDX_W-1:0]     r_gnt_id;
    logic [NUM_CORES-1:0] r_core_valid;
    logic [DATA_W-1:0]    r_core_data;
    logic                 r_ld_ack;
    logic [ADDR_W-1:0]    r_mem_pc;
    logic                 r_mem_we;
    logic [DATA_W-1:0]    r_mem_dado;
    logic                 r_busy;

    // ------------------------------------------------------------------
    // Next-state / next-output wires
    // ------------------------------------------------------------------
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     w_last_grant_nxt;
    logic [IDX_W-1:0]     w_gnt_id_nxt;
    logic [NUM_CORES-1:0] w_core_valid_nxt;
    logic [DATA_W-1:0]    w_core_data_nxt;
    logic                 w_ld_ack_nxt;
    logic [ADDR_W-1:0]    w_mem_pc_nxt;
    logic                 w_mem_we_nxt;
    logic [DATA_W-1:0]    w_mem_dado_nxt;

    // Arbitration helpers
    logic [NUM_CORES-1:0] w_masked;
    logic                 w_rr_found;
    logic [IDX_W-1:0]     w_rr_pick;
    logic [ADDR_W-1:0]    w_sel_addr;

    // A core whose core_valid is high this cycle may not have dropped its
    // request yet; hiding it here prevents serving the same fetch twice.
    assign w_masked = core_req & ~r_core_valid;

    // Round-robin search starting one past the last granted core.
    always_comb begin
        int               w_idx;
        logic [IDX_W-1:0] w_idx_sel;
        w_rr_found = 1'b0;
        w_rr_pick  = '0;
        w_idx      = 0;
        w_idx_sel  = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            w_idx     = (int'(r_last_grant) + k) % NUM_CORES;
            w_idx_sel = IDX_W'(w_idx);
            if (!w_rr_found && w_masked[w_idx_sel]) begin
                w_rr_found = 1'b1;
                w_rr_pick  = w_idx_sel;
            end
        end
    end

    assign w_sel_addr = core_addr[int'(w_rr_pick)*ADDR_W +: ADDR_W];

    // ------------------------------------------------------------------
    // FSM: next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_gnt_id_nxt     = r_gnt_id;
        w_core_valid_nxt = '0;
        w_core_data_nxt  = r_core_data;
        w_ld_ack_nxt     = 1'b0;
        w_mem_pc_nxt     = r_mem_pc;
        w_mem_we_nxt     = 1'b0;
        w_mem_dado_nxt   = r_mem_dado;

        case (r_state)
            S_IDLE: begin
                if (ld_req) begin
                    // Loader wins outright; last_grant is left untouched.
                    w_mem_pc_nxt   = ld_addr;
                    w_mem_dado_nxt = ld_data;
                    w_mem_we_nxt   = 1'b1;
                    w_state_nxt    = S_WRITE;
                end else if (w_rr_found) begin
                    w_gnt_id_nxt = w_rr_pick;
                    w_mem_pc_nxt = w_sel_addr;
                    w_state_nxt  = S_READ;
                end
            end
            S_WRITE: begin
                // The memory commits the write at this edge.
                w_ld_ack_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            S_READ: begin
                // The memory registers the read word at this edge.
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                w_core_data_nxt            = mem_instr;
                w_core_valid_nxt[r_gnt_id] = 1'b1;
                w_last_grant_nxt           = r_gnt_id;
                w_state_nxt                = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Registered datapath and outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (clear) begin
            r_last_grant <= IDX_W'(NUM_CORES - 1);
            r_gnt_id     <= '0;
            r_core_valid <= '0;
            r_core_data  <= '0;
            r_ld_ack     <= 1'b0;
            r_mem_pc     <= '0;
            r_mem_we     <= 1'b0;
            r_mem_dado   <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_last_grant <= w_last_grant_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_core_valid <= w_core_valid_nxt;
            r_core_data  <= w_core_data_nxt;
            r_ld_ack     <= w_ld_ack_nxt;
            r_mem_pc     <= w_mem_pc_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_dado   <= w_mem_dado_nxt;
            // busy tracks the state register, so it is high exactly while
            // the FSM sits outside IDLE.
            r_busy       <= (w_state_nxt != S_IDLE);
        end
    end

    assign core_valid   = r_core_valid;
    assign core_data    = r_core_data;
    assign ld_ack       = r_ld_ack;
    assign mem_pc       = r_mem_pc;
    assign mem_hab_escr = r_mem_we;
    assign mem_dado     = r_mem_dado;
    assign busy         = r_busy;

`ifdef INSTR_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Contended-grant counter
    // ------------------------------------------------------------------
    logic        w_grant;
    logic        w_contended;
    logic [15:0] r_stat_conflicts;

    assign w_grant = (r_state == S_IDLE) && (ld_req || w_rr_found);

    // Two or more of {loader, masked cores}: either the loader plus any
    // core, or at least two core bits (x & (x-1) clears the lowest set bit).
    assign w_contended = ld_req ? (|w_masked)
                                : ((w_masked & (w_masked - NUM_CORES'(1))) != '0);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_stat_conflicts <= '0;
        end else if (w_grant && w_contended && (r_stat_conflicts != 16'hFFFF)) begin
            r_stat_conflicts <= r_stat_conflicts + 16'd1;
        end
    end

    assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter with a registered-read memory model.
module tb_instr_mem_arbiter;

    localparam int NUM_CORES = 2;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 10;

    logic                        clock;
    logic                        clear;
    logic [NUM_CORES-1:0]        core_req;
    logic [NUM_CORES*ADDR_W-1:0] core_addr;
    logic [NUM_CORES-1:0]        core_valid;
    logic [DATA_W-1:0]           core_data;
    logic                        ld_req;
    logic [ADDR_W-1:0]           ld_addr;
    logic [DATA_W-1:0]           ld_data;
    logic                        ld_ack;
    logic [ADDR_W-1:0]           mem_pc;
    logic                        mem_hab_escr;
    logic [DATA_W-1:0]           mem_dado;
    logic [DATA_W-1:0]           mem_instr;
    logic                        busy;
`ifdef INSTR_ARB_STATS_EN
    logic [15:0]                 stat_conflicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_mem_arbiter #(
        .NUM_CORES(NUM_CORES),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_valid  (core_valid),
        .core_data   (core_data),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .mem_pc      (mem_pc),
        .mem_hab_escr(mem_hab_escr),
        .mem_dado    (mem_dado),
        .mem_instr   (mem_instr),
        .busy        (busy)
`ifdef INSTR_ARB_STATS_EN
        ,
        .stat_conflicts(stat_conflicts)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory: word i initially holds value i; registered read.
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
        mem_instr = '0;
    end
    always @(posedge clock) begin
        if (mem_hab_escr) mem[mem_pc] <= mem_dado;
        mem_instr <= mem[mem_pc];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        clear     = 1'b1;
        core_req  = '0;
        core_addr = '0;
        ld_req    = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        // ---- reset state ----
        tick(); tick();
        chk("rst_valid", 32'(core_valid), 32'h0);
        chk("rst_data",  32'(core_data),  32'h0);
        chk("rst_ack",   32'(ld_ack),     32'h0);
        chk("rst_pc",    32'(mem_pc),     32'h0);
        chk("rst_we",    32'(mem_hab_escr), 32'h0);
        chk("rst_dado",  32'(mem_dado),   32'h0);
        chk("rst_busy",  32'(busy),       32'h0);

        // ---- single fetch core0 @3 ----
        clear     = 1'b0;
        core_req  = 2'b01;
        core_addr = {5'd0, 5'd3};
        tick();                                    // grant edge
        chk("f1_pc",    32'(mem_pc), 32'd3);
        chk("f1_busy",  32'(busy),   32'd1);
        chk("f1_v0",    32'(core_valid), 32'h0);
        tick();                                    // READ edge
        chk("f1_v1",    32'(core_valid), 32'h0);
        tick();                                    // RESP edge
        chk("f1_valid", 32'(core_valid), 32'b01);
        chk("f1_data",  32'(core_data),  32'h003);
        chk("f1_busy2", 32'(busy),       32'd0);
        core_req = 2'b00;
        tick();
        chk("f1_vdrop", 32'(core_valid), 32'h0);
        chk("f1_hold",  32'(core_data),  32'h003);

        // ---- round robin, fresh reset so core0 is first ----
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        core_req  = 2'b11;
        core_addr = {5'd2, 5'd1};
        for (int f = 0; f < 4; f++) begin
            tick();
            chk("rr_pc", 32'(mem_pc), (f % 2 == 0) ? 32'd1 : 32'd2);
            tick(); tick();
            chk("rr_valid", 32'(core_valid), (f % 2 == 0) ? 32'b01 : 32'b10);
            chk("rr_data",  32'(core_data),  (f % 2 == 0) ? 32'd1 : 32'd2);
        end
        core_req = 2'b00;
        tick();
        chk("rr_idle", 32'(busy), 32'd0);

        // ---- loader priority over simultaneous core requests ----
        core_req  = 2'b11;
        core_addr = {5'd2, 5'd1};
        ld_req    = 1'b1;
        ld_addr   = 5'd9;
        ld_data   = 10'h2AA;
        tick();                                    // grant to loader
        chk("ld_we1",  32'(mem_hab_escr), 32'd1);
        chk("ld_pc",   32'(mem_pc),       32'd9);
        chk("ld_dado", 32'(mem_dado),     32'h2AA);
        chk("ld_ack0", 32'(ld_ack),       32'd0);
        tick();                                    // write commits
        chk("ld_we0",  32'(mem_hab_escr), 32'd0);
        chk("ld_ack1", 32'(ld_ack),       32'd1);
        ld_req  = 1'b0;
        ld_addr = 5'd30;                           // must not matter any more
        tick();                                    // core0 granted
        chk("ld_ackp", 32'(ld_ack), 32'd0);
        chk("ld_c0pc", 32'(mem_pc), 32'd1);
        tick(); tick();
        chk("ld_c0v",  32'(core_valid), 32'b01);
        chk("ld_c0d",  32'(core_data),  32'd1);
        core_req  = 2'b10;
        core_addr = {5'd9, 5'd1};
        tick();
        chk("ld_c1pc", 32'(mem_pc), 32'd9);
        tick(); tick();
        chk("ld_rbv",  32'(core_valid), 32'b10);
        chk("ld_rbd",  32'(core_data),  32'h2AA);
        core_req = 2'b00;
        tick();

        // ---- clear during READ ----
        core_req  = 2'b01;
        core_addr = {5'd0, 5'd4};
        tick();                                    // grant, now READ
        chk("cl_pc", 32'(mem_pc), 32'd4);
        clear = 1'b1;
        tick();
        chk("cl_valid", 32'(core_valid), 32'h0);
        chk("cl_data",  32'(core_data),  32'h0);
        chk("cl_pc0",   32'(mem_pc),     32'h0);
        chk("cl_busy",  32'(busy),       32'h0);
        clear = 1'b0;
        tick();                                    // re-grant core0
        chk("cl_regnt", 32'(mem_pc), 32'd4);
        chk("cl_novld", 32'(core_valid), 32'h0);
        tick(); tick();
        chk("cl_valid2", 32'(core_valid), 32'b01);
        chk("cl_data2",  32'(core_data),  32'd4);
        core_req = 2'b00;
        tick();

        // ---- hold masking: core0 keeps req through its valid cycle ----
        core_req  = 2'b01;
        core_addr = {5'd0, 5'd7};
        tick();
        chk("hm_pc", 32'(mem_pc), 32'd7);
        tick(); tick();
        chk("hm_valid", 32'(core_valid), 32'b01);
        chk("hm_data",  32'(core_data),  32'd7);
        tick();                                    // req still high: no re-grant
        chk("hm_nobusy", 32'(busy),       32'd0);
        chk("hm_novld",  32'(core_valid), 32'h0);
        core_req = 2'b00;
        tick();

`ifdef INSTR_ARB_STATS_EN
        // ---- conflict counter: 4 contended loader grants, 1 lone fetch ----
        clear = 1'b1;
        tick();
        chk("st_rst", 32'(stat_conflicts), 32'd0);
        clear    = 1'b0;
        core_req = 2'b01;
        ld_req   = 1'b1;
        ld_addr  = 5'd20;
        ld_data  = 10'h155;
        for (int w = 0; w < 4; w++) begin
            tick(); tick();
        end
        ld_req = 1'b0;
        tick(); tick(); tick();
        chk("st_valid", 32'(core_valid), 32'b01);
        chk("st_count", 32'(stat_conflicts), 32'd4);
        core_req = 2'b00;
        tick();
        force dut.r_stat_conflicts = 16'hFFFE;
        tick();
        release dut.r_stat_conflicts;
        core_req = 2'b01;
        ld_req   = 1'b1;
        for (int w = 0; w < 2; w++) begin
            tick(); tick();
        end
        ld_req   = 1'b0;
        core_req = 2'b00;
        chk("st_sat", 32'(stat_conflicts), 32'hFFFF);
        tick(); tick(); tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
